// File: rtl/uart_pkg.sv
// Shared constants and types for the UART tick generation blocks.
package uart_pkg;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FRAC_W     = 4;
  localparam int DEF_OVERSAMPLE = 16;

  // A programmed integer divisor below this is treated as this value.
  localparam int DIV_MIN = 1;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]  div_int;
    logic [DEF_FRAC_W-1:0] div_frac;
  } div_pair_t;

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle between the baud generator and its UART user.
interface uart_baud_gen_frac_if #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4
);

  logic              en;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              resync;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              div_pending;

  modport master (
    output en, div_int, div_frac, div_load, resync,
    input  os_tick, mid_tick, bit_tick, div_pending
  );

  modport slave (
    input  en, div_int, div_frac, div_load, resync,
    output os_tick, mid_tick, bit_tick, div_pending
  );

endinterface

// File: rtl/uart_os_counter.sv
// Oversample index counter; flags the mid-bit and end-of-bit oversample ticks.
module uart_os_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic clear,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [OS_W-1:0] os_idx;

  // Ticks are decoded from the index value before it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_idx   <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (clear) begin
      os_idx   <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (step) begin
      mid_tick <= (os_idx == OS_W'(OVERSAMPLE / 2 - 1));
      bit_tick <= (os_idx == OS_W'(OVERSAMPLE - 1));
      os_idx   <= (os_idx == OS_W'(OVERSAMPLE - 1)) ? '0 : os_idx + OS_W'(1);
    end else begin
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud tick generator: os/mid/bit strobes from one clock.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_baud_gen_frac_if.slave  bus
);

  typedef struct packed {
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } div_reg_t;

  div_reg_t          div_in;
  div_reg_t          div_act;
  div_reg_t          div_pend;
  logic              div_pending_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  d_eff;
  logic [CNT_W-1:0]  lim;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [FRAC_W:0]   acc_sum;
  logic              os_tick_q;
  logic              mid_q;
  logic              bit_q;
  logic              terminal;
  logic              step;

  assign div_in   = '{div_int: bus.div_int, div_frac: bus.div_frac};
  assign d_eff    = (div_act.div_int < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_act.div_int;
  assign lim      = d_eff - CNT_W'(1) + CNT_W'(extra);
  // >= so a divisor shrink applied while idle can never strand cnt past lim.
  assign terminal = (cnt >= lim);
  assign step     = bus.en && terminal && !bus.resync;
  assign acc_sum  = {1'b0, acc} + {1'b0, div_act.div_frac};

  // Cycle counter, phase accumulator and divisor staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      acc           <= '0;
      extra         <= 1'b0;
      os_tick_q     <= 1'b0;
      div_act       <= '0;
      div_pend      <= '0;
      div_pending_q <= 1'b0;
    end else if (bus.resync) begin
      cnt       <= '0;
      acc       <= '0;
      extra     <= 1'b0;
      os_tick_q <= 1'b0;
      if (bus.div_load) begin
        div_act       <= div_in;
        div_pending_q <= 1'b0;
      end else if (div_pending_q) begin
        div_act       <= div_pend;
        div_pending_q <= 1'b0;
      end
    end else begin
      if (bus.en && terminal) begin
        cnt            <= '0;
        {extra, acc}   <= acc_sum;
        os_tick_q      <= 1'b1;
      end else if (bus.en) begin
        cnt       <= cnt + CNT_W'(1);
        os_tick_q <= 1'b0;
      end else begin
        os_tick_q <= 1'b0;
      end
      if (bus.div_load) begin
        div_pend      <= div_in;
        div_pending_q <= 1'b1;
      end else if (div_pending_q && (terminal || !bus.en)) begin
        div_act       <= div_pend;
        div_pending_q <= 1'b0;
      end
    end
  end

  uart_os_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_counter (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .clear    (bus.resync),
    .mid_tick (mid_q),
    .bit_tick (bit_q)
  );

  assign bus.os_tick     = os_tick_q;
  assign bus.mid_tick    = mid_q;
  assign bus.bit_tick    = bit_q;
  assign bus.div_pending = div_pending_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac with an expected-interval scoreboard.
module tb_uart_baud_gen_frac;
  import uart_pkg::*;

  typedef struct {
    int   interval;
    logic mid_f;
    logic bit_f;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   last_tick = 0;
  int   checks = 0;
  int   passes = 0;
  int   fails = 0;
  int   m_acc, m_extra, m_idx;
  exp_t sb[$];
  int   bit_cyc[$];

  uart_baud_gen_frac_if #(.CNT_W(DEF_CNT_W), .FRAC_W(DEF_FRAC_W)) bus ();

  uart_baud_gen_frac #(
    .CNT_W      (DEF_CNT_W),
    .FRAC_W     (DEF_FRAC_W),
    .OVERSAMPLE (DEF_OVERSAMPLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_extra = 0;
    m_idx   = 0;
    bit_cyc.delete();
  endtask

  // Reference: interval d+extra, carry from the 4-bit phase sum, 16 os ticks per bit.
  task automatic push_ticks(input int d, input int frac, input int n, input int stall);
    exp_t e;
    int   sum;
    for (int i = 0; i < n; i++) begin
      e.interval = ((d < 1) ? 1 : d) + m_extra + ((i == 0) ? stall : 0);
      e.mid_f    = (m_idx == 7);
      e.bit_f    = (m_idx == 15);
      sum        = m_acc + frac;
      m_extra    = (sum >= 16) ? 1 : 0;
      m_acc      = sum % 16;
      m_idx      = (m_idx + 1) % 16;
      sb.push_back(e);
    end
  endtask

  task automatic expect_ticks(input int n, input string tag);
    exp_t e;
    logic got;
    for (int t = 0; t < n; t++) begin
      got = 1'b0;
      for (int k = 0; k < 1000 && !got; k++) begin
        @(negedge clk);
        if (bus.os_tick === 1'b1) got = 1'b1;
        else check_output({tag, " stray_tick"}, {30'd0, bus.mid_tick, bus.bit_tick}, 32'd0);
      end
      if (sb.size() == 0) begin
        check_output({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        if (!got) begin
          check_output({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
          check_output({tag, " interval"}, cyc - last_tick, e.interval);
          check_output({tag, " mid"}, {31'd0, bus.mid_tick}, {31'd0, e.mid_f});
          check_output({tag, " bit"}, {31'd0, bus.bit_tick}, {31'd0, e.bit_f});
          last_tick = cyc;
          if (bus.bit_tick === 1'b1) bit_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic check_bit_period(input string tag, input int exp);
    if (bit_cyc.size() >= 2)
      check_output(tag, bit_cyc[bit_cyc.size()-1] - bit_cyc[bit_cyc.size()-2], exp);
    else
      check_output({tag, " missing"}, bit_cyc.size(), 2);
  endtask

  // Load and resync together: divisor active at once, phase restarted.
  task automatic apply_stimulus(input int int_v, input int frac_v);
    bus.div_int  = 16'(int_v);
    bus.div_frac = 4'(frac_v);
    bus.div_load = 1'b1;
    bus.resync   = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    last_tick    = cyc;
    model_reset();
    check_output("load_resync pending", {31'd0, bus.div_pending}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset os_tick", {31'd0, bus.os_tick}, 32'd0);
    check_output("reset mid_tick", {31'd0, bus.mid_tick}, 32'd0);
    check_output("reset bit_tick", {31'd0, bus.bit_tick}, 32'd0);
    check_output("reset pending", {31'd0, bus.div_pending}, 32'd0);

    $display("[TB] default divisor after reset");
    rst       = 1'b0;
    last_tick = cyc;
    model_reset();
    push_ticks(0, 0, 32, 0);
    expect_ticks(32, "default");
    check_bit_period("default bit_period", 16);

    $display("[TB] fractional 27 + 2/16");
    apply_stimulus(27, 2);
    push_ticks(27, 2, 32, 0);
    expect_ticks(32, "frac27");
    check_bit_period("frac27 bit_period", 434);

    $display("[TB] integer 4");
    apply_stimulus(4, 0);
    push_ticks(4, 0, 32, 0);
    expect_ticks(32, "int4");
    check_bit_period("int4 bit_period", 64);

    $display("[TB] divisor 0 and 1");
    apply_stimulus(0, 0);
    push_ticks(0, 0, 32, 0);
    expect_ticks(32, "div0");
    check_bit_period("div0 bit_period", 16);
    apply_stimulus(1, 0);
    push_ticks(1, 0, 16, 0);
    expect_ticks(16, "div1");

    $display("[TB] mid-interval divisor load");
    apply_stimulus(10, 0);
    push_ticks(10, 0, 2, 0);
    expect_ticks(2, "load10");
    repeat (3) @(negedge clk);
    bus.div_int  = 16'd5;
    bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    check_output("load pending_set", {31'd0, bus.div_pending}, 32'd1);
    push_ticks(10, 0, 1, 0);
    expect_ticks(1, "load_old");
    check_output("load pending_clr", {31'd0, bus.div_pending}, 32'd0);
    push_ticks(5, 0, 3, 0);
    expect_ticks(3, "load_new");

    $display("[TB] resync at terminal count");
    apply_stimulus(4, 0);
    push_ticks(4, 0, 2, 0);
    expect_ticks(2, "pre_resync");
    repeat (3) @(negedge clk);
    bus.resync = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    check_output("resync no_tick", {31'd0, bus.os_tick}, 32'd0);
    last_tick = cyc;
    model_reset();
    push_ticks(4, 0, 16, 0);
    expect_ticks(16, "post_resync");
    check_output("resync bit_count", bit_cyc.size(), 1);

    $display("[TB] enable stall then async reset");
    apply_stimulus(10, 0);
    push_ticks(10, 0, 1, 0);
    expect_ticks(1, "pre_stall");
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_output("stall os_tick", {31'd0, bus.os_tick}, 32'd0);
    end
    bus.en = 1'b1;
    push_ticks(10, 0, 1, 7);
    expect_ticks(1, "stall_resume");
    repeat (3) @(negedge clk);
    bus.div_int  = 16'd6;
    bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    check_output("prerst pending", {31'd0, bus.div_pending}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("async_rst outputs",
                 {28'd0, bus.os_tick, bus.mid_tick, bus.bit_tick, bus.div_pending}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    last_tick = cyc;
    model_reset();
    push_ticks(0, 0, 4, 0);
    expect_ticks(4, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
